// File: rtl/him_row_unpacker_if.sv
// Bundle of the request, HIM read and hit-stream channels of the HIM row unpacker.
// The slave modport is the unpacker's view; master is the surrounding logic's view.
interface him_row_unpacker_if #(
  parameter int ROWINDEXBITS_HIM = 10,
  parameter int HITINFOBITS      = 16,
  parameter int MAXHITS          = 8,
  parameter int MAXHITNBITS      = 4
);
  localparam int NCOLS_HIM = MAXHITS * HITINFOBITS;

  // Request channel from the road/pattern lookup stage
  logic                        req_valid;
  logic                        req_ready;
  logic [ROWINDEXBITS_HIM-1:0] req_row;
  logic [MAXHITNBITS-1:0]      req_nHits;

  // Read port of the hit info memory
  logic                        himReadRow;
  logic [ROWINDEXBITS_HIM-1:0] himRowToRead;
  logic                        himReadReady;
  logic                        himReadFinished;
  logic [NCOLS_HIM-1:0]        himHitInfo;

  // Hit stream towards the track-fitting input FIFO
  logic                        hit_valid;
  logic                        hit_ready;
  logic [HITINFOBITS-1:0]      hit_data;
  logic [ROWINDEXBITS_HIM-1:0] hit_row;
  logic                        hit_last;

  // Status pulses
  logic                        rowDone;
  logic                        overflow;
  logic                        timeoutError;

  modport slave (
    input  req_valid, req_row, req_nHits,
    input  himReadReady, himReadFinished, himHitInfo,
    input  hit_ready,
    output req_ready,
    output himReadRow, himRowToRead,
    output hit_valid, hit_data, hit_row, hit_last,
    output rowDone, overflow, timeoutError
  );

  modport master (
    output req_valid, req_row, req_nHits,
    output himReadReady, himReadFinished, himHitInfo,
    output hit_ready,
    input  req_ready,
    input  himReadRow, himRowToRead,
    input  hit_valid, hit_data, hit_row, hit_last,
    input  rowDone, overflow, timeoutError
  );
endinterface

// File: rtl/him_row_unpacker.sv
// HIM row unpacker: accepts a (row, hit count) request, issues one HIM read,
// waits for the row data with a timeout, then streams the packed hit words
// one per handshake with a last-hit marker.
module him_row_unpacker #(
  parameter int ROWINDEXBITS_HIM = 10,
  parameter int HITINFOBITS      = 16,
  parameter int MAXHITS          = 8,
  parameter int MAXHITNBITS      = 4,
  parameter int TIMEOUT          = 64
) (
  input logic               clk,
  input logic               reset,
  him_row_unpacker_if.slave bus
);

  localparam int NCOLS_HIM = MAXHITS * HITINFOBITS;
  localparam int CNTW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [MAXHITNBITS-1:0] MAXHITS_N = MAXHITNBITS'(MAXHITS);
  localparam logic [MAXHITNBITS-1:0] ONE_N     = MAXHITNBITS'(1);
  localparam logic [CNTW-1:0]        CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0]        CNT_LAST  = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STREAM
  } state_t;

  state_t                      r_state;
  logic [ROWINDEXBITS_HIM-1:0] r_row;        // latched request row
  logic [MAXHITNBITS-1:0]      r_count;      // latched (clamped) hit count
  logic [MAXHITNBITS-1:0]      r_remaining;  // hits still to emit, >= 1 in STREAM
  logic [NCOLS_HIM-1:0]        r_shift;      // captured row, current hit in the LSBs
  logic [CNTW-1:0]             r_cnt;        // cycles spent in WAIT
  logic                        r_row_done;
  logic                        r_overflow;
  logic                        r_timeout;

  logic w_issue;
  logic w_hit_fire;
  logic w_last_hit;

  // Handshake qualifiers derived from the current state and live inputs
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here trivially),
    // otherwise a latch is inferred to hold the old value.
    w_issue    = (r_state == S_ISSUE) && bus.himReadReady;
    w_hit_fire = (r_state == S_STREAM) && bus.hit_ready;
    w_last_hit = (r_remaining == ONE_N);
  end

  // Control FSM with the row/shift datapath and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide shift register is reset too, because hit_data is taken
      // straight from it and must read as zero after reset.
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_row_done  <= 1'b0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      r_row_done <= 1'b0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_row <= bus.req_row;
            if (bus.req_nHits == '0) begin
              // Empty row: complete immediately without touching the HIM
              r_count    <= '0;
              r_row_done <= 1'b1;
            end else if (bus.req_nHits > MAXHITS_N) begin
              // More hits claimed than a row can hold: clamp and flag
              r_count    <= MAXHITS_N;
              r_overflow <= 1'b1;
              r_state    <= S_ISSUE;
            end else begin
              r_count <= bus.req_nHits;
              r_state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (w_issue) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.himReadFinished) begin
            // A finish on the final allowed cycle still wins over the timeout
            r_shift     <= bus.himHitInfo;
            r_remaining <= r_count;
            r_state     <= S_STREAM;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout  <= 1'b1;
            r_row_done <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_STREAM: begin
          if (w_hit_fire) begin
            r_shift <= r_shift >> HITINFOBITS;
            if (w_last_hit) begin
              r_row_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_remaining <= r_remaining - ONE_N;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output drive: everything comes from registers except the read strobe,
  // which must follow himReadReady within the same cycle, and req_ready,
  // which is held low while reset is asserted.
  assign bus.req_ready    = (r_state == S_IDLE) && !reset;
  assign bus.himReadRow   = w_issue;
  assign bus.himRowToRead = r_row;
  assign bus.hit_valid    = (r_state == S_STREAM);
  assign bus.hit_data     = r_shift[HITINFOBITS-1:0];
  assign bus.hit_row      = r_row;
  assign bus.hit_last     = (r_state == S_STREAM) && w_last_hit;
  assign bus.rowDone      = r_row_done;
  assign bus.overflow     = r_overflow;
  assign bus.timeoutError = r_timeout;

endmodule
